// File: rtl/mac_out_packer.sv
// mac_out_packer: collects 16-bit MAC results from a narrow-use input stream
// and packs N consecutive results into one full-width output beat. A packet
// (input tlast) is flushed as a final, possibly partial, beat whose tkeep
// marks the populated lanes. Run control follows the ap_ctrl handshake.
module mac_out_packer #(
  parameter int C_S_AXIS_IN_TDATA_WIDTH  = 1024,
  parameter int C_M_AXIS_OUT_TDATA_WIDTH = 1024,
  parameter int C_LANE_WIDTH             = 16
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic                                    s_axis_in_tvalid,
  output logic                                    s_axis_in_tready,
  input  logic [C_S_AXIS_IN_TDATA_WIDTH-1:0]      s_axis_in_tdata,
  input  logic [C_S_AXIS_IN_TDATA_WIDTH/8-1:0]    s_axis_in_tkeep,
  input  logic                                    s_axis_in_tlast,
  output logic                                    m_axis_out_tvalid,
  input  logic                                    m_axis_out_tready,
  output logic [C_M_AXIS_OUT_TDATA_WIDTH-1:0]     m_axis_out_tdata,
  output logic [C_M_AXIS_OUT_TDATA_WIDTH/8-1:0]   m_axis_out_tkeep,
  output logic                                    m_axis_out_tlast,
  input  logic                                    ap_start,
  output logic                                    ap_idle,
  output logic                                    ap_done,
  output logic                                    ap_ready
);

  localparam int N          = C_M_AXIS_OUT_TDATA_WIDTH / C_LANE_WIDTH;
  localparam int CNT_W      = $clog2(N);
  localparam int KEEP_W     = C_M_AXIS_OUT_TDATA_WIDTH / 8;
  localparam int LANE_BYTES = C_LANE_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                              state;
  state_t                              state_next;
  logic                                start_d;
  logic                                start_pulse;
  logic [CNT_W-1:0]                    lane_cnt;
  logic [C_M_AXIS_OUT_TDATA_WIDTH-1:0] pack;
  logic [C_M_AXIS_OUT_TDATA_WIDTH-1:0] pack_next;
  logic [C_M_AXIS_OUT_TDATA_WIDTH-1:0] out_data;
  logic [KEEP_W-1:0]                   out_keep;
  logic                                out_last;
  logic                                out_valid;
  logic                                done;
  logic                                in_ready;
  logic                                accept;
  logic                                word_done;
  logic                                out_hs;
  logic                                unused_in;

  // tkeep for a beat whose highest populated lane is last_lane
  function automatic logic [KEEP_W-1:0] keep_upto(input logic [CNT_W-1:0] last_lane);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) <= last_lane) k[i*LANE_BYTES +: LANE_BYTES] = '1;
    end
    return k;
  endfunction

  // Upper input bits and input tkeep carry nothing for this block
  assign unused_in = ^{s_axis_in_tkeep, s_axis_in_tdata[C_S_AXIS_IN_TDATA_WIDTH-1:C_LANE_WIDTH]};

  assign start_pulse = ap_start & ~start_d;
  assign in_ready    = (state == BUSY) && (!out_valid || m_axis_out_tready);
  assign accept      = s_axis_in_tvalid && in_ready;
  assign word_done   = accept && ((lane_cnt == CNT_W'(N - 1)) || s_axis_in_tlast);
  assign out_hs      = out_valid && m_axis_out_tready;

  assign s_axis_in_tready  = in_ready;
  assign m_axis_out_tvalid = out_valid;
  assign m_axis_out_tdata  = out_data;
  assign m_axis_out_tkeep  = out_keep;
  assign m_axis_out_tlast  = out_last;
  assign ap_done           = done;
  assign ap_idle           = (state == IDLE);
  assign ap_ready          = (state == IDLE);

  // Pack register with the incoming result dropped into the current lane
  always_comb begin
    pack_next = pack;
    for (int i = 0; i < N; i++) begin
      if (lane_cnt == CNT_W'(i)) pack_next[i*C_LANE_WIDTH +: C_LANE_WIDTH] = s_axis_in_tdata[C_LANE_WIDTH-1:0];
    end
  end

  // Run-control next state; stray start pulses outside IDLE fall through
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_pulse) state_next = BUSY;
      BUSY:    if (accept && s_axis_in_tlast) state_next = DRAIN;
      DRAIN:   if (out_hs && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, start edge detector and completion pulse
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      start_d <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      start_d <= ap_start;
      done    <= out_hs && out_last;
    end
  end

  // Lane counter and pack register; a completed word restarts at lane 0
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lane_cnt <= '0;
      pack     <= '0;
    end else if (word_done) begin
      lane_cnt <= '0;
      pack     <= '0;
    end else if (accept) begin
      lane_cnt <= lane_cnt + 1'b1;
      pack     <= pack_next;
    end
  end

  // Output register: a new word wins over a same-cycle handshake clear
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (word_done) begin
      out_data  <= pack_next;
      out_keep  <= keep_upto(lane_cnt);
      out_last  <= s_axis_in_tlast;
      out_valid <= 1'b1;
    end else if (out_hs) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_out_packer.sv
// Testbench for mac_out_packer: table-driven packets plus hand-written
// control, backpressure and reset sequences.
module tb_mac_out_packer;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [1023:0]  in_data;
  logic [127:0]   in_keep;
  logic           in_last;
  logic           m_valid;
  logic           m_ready;
  logic [1023:0]  m_data;
  logic [127:0]   m_keep;
  logic           m_last;
  logic           ap_start;
  logic           ap_idle;
  logic           ap_done;
  logic           ap_ready;

  typedef struct {
    logic [1023:0] d;
    logic [127:0]  k;
    logic          l;
  } beat_t;

  typedef struct {
    string        name;
    int           n;
    int           base;
    bit           explicit_vals;
    logic [15:0]  t0;
    logic [15:0]  t1;
    logic [15:0]  t2;
    int           exp_beats;
    logic [127:0] last_keep;
  } vec_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [15:0] vq[$];
  vec_t        tbl[5];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          hs_last_cyc = 0;

  mac_out_packer dut (
    .ap_clk            (clk),
    .ap_rst_n          (rst_n),
    .s_axis_in_tvalid  (in_valid),
    .s_axis_in_tready  (in_ready),
    .s_axis_in_tdata   (in_data),
    .s_axis_in_tkeep   (in_keep),
    .s_axis_in_tlast   (in_last),
    .m_axis_out_tvalid (m_valid),
    .m_axis_out_tready (m_ready),
    .m_axis_out_tdata  (m_data),
    .m_axis_out_tkeep  (m_keep),
    .m_axis_out_tlast  (m_last),
    .ap_start          (ap_start),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done),
    .ap_ready          (ap_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted beats and ap_done pulses
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back('{m_data, m_keep, m_last});
      if (m_last) hs_last_cyc = cyc;
    end
    if (ap_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int lane;
    lane = 0;
    vectors++;
    if (act !== exp) begin
      errors++;
      for (int i = 63; i >= 0; i--) if (act[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
      $display("FAIL %s: lane %0d actual %h required %h", nm, lane, act[lane*16 +: 16], exp[lane*16 +: 16]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 1024'(in_ready), 1024'(0));
    chk({tag, "_tvalid"},   1024'(m_valid),  1024'(0));
    chk({tag, "_tdata"},    m_data,          1024'(0));
    chk({tag, "_tkeep"},    1024'(m_keep),   1024'(0));
    chk({tag, "_tlast"},    1024'(m_last),   1024'(0));
    chk({tag, "_done"},     1024'(ap_done),  1024'(0));
    chk({tag, "_idle"},     1024'(ap_idle),  1024'(1));
    chk({tag, "_ready"},    1024'(ap_ready), 1024'(1));
  endtask

  // Reference packing: 64 lanes per beat, packet end flushes a partial beat
  function automatic void build_exp();
    logic [1023:0] cur;
    logic [127:0]  k;
    int            lane;
    exp_q.delete();
    cur = '0;
    for (int i = 0; i < vq.size(); i++) begin
      lane = i % 64;
      cur[lane*16 +: 16] = vq[i];
      if (lane == 63 || i == vq.size() - 1) begin
        k = '0;
        for (int j = 0; j <= lane; j++) k[j*2 +: 2] = 2'b11;
        exp_q.push_back('{cur, k, (i == vq.size() - 1)});
        cur = '0;
      end
    end
  endfunction

  task automatic send_beat(input logic [15:0] v, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = {{63{v ^ 16'h5A5A}}, v};
    in_last  = last;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("send_ready_timeout", 1024'(in_ready), 1024'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit with_last);
    for (int i = lo; i < hi; i++) send_beat(vq[i], with_last && (i == hi - 1));
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (done_cnt == 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done_seen"}, 1024'(done_cnt > 0), 1024'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    chk({tag, "_beats"}, 1024'(got_q.size()), 1024'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int b = 0; b < n; b++) begin
      chk($sformatf("%s_b%0d_data", tag, b), got_q[b].d, exp_q[b].d);
      chk($sformatf("%s_b%0d_keep", tag, b), 1024'(got_q[b].k), 1024'(exp_q[b].k));
      chk($sformatf("%s_b%0d_last", tag, b), 1024'(got_q[b].l), 1024'(exp_q[b].l));
    end
  endtask

  task automatic run_case(input vec_t r);
    vq.delete();
    for (int i = 0; i < r.n; i++) begin
      if (r.explicit_vals) vq.push_back((i == 0) ? r.t0 : (i == 1) ? r.t1 : r.t2);
      else vq.push_back(16'(r.base + i));
    end
    build_exp();
    got_q.delete();
    done_cnt = 0;
    start_pulse();
    send_range(0, r.n, 1'b1);
    wait_done(r.name);
    chk({r.name, "_beat_count"}, 1024'(got_q.size()), 1024'(r.exp_beats));
    compare_beats(r.name);
    if (got_q.size() > 0) chk({r.name, "_final_keep"}, 1024'(got_q[got_q.size()-1].k), 1024'(r.last_keep));
    chk({r.name, "_done_once"}, 1024'(done_cnt), 1024'(1));
    chk({r.name, "_done_timing"}, 1024'(done_cyc), 1024'(hs_last_cyc + 1));
    chk({r.name, "_idle_after"}, 1024'(ap_idle), 1024'(1));
  endtask

  task automatic no_ready_window(input string tag, input int ncyc);
    int seen;
    seen = 0;
    in_valid = 1'b1;
    in_data  = 1024'h1234;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (in_ready) seen++;
    end
    chk({tag, "_no_tready"}, 1024'(seen), 1024'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '1;
    in_last  = 1'b0;
    m_ready  = 1'b1;
    ap_start = 1'b0;

    tbl[0] = '{"full",   64,  1,          1'b0, 16'h0,    16'h0,    16'h0,    1, {128{1'b1}}};
    tbl[1] = '{"short",  3,   0,          1'b1, 16'hAAAA, 16'h0001, 16'hFFFF, 1, 128'h3F};
    tbl[2] = '{"multi",  130, 0,          1'b0, 16'h0,    16'h0,    16'h0,    3, 128'hF};
    tbl[3] = '{"two",    128, 'h1000,     1'b0, 16'h0,    16'h0,    16'h0,    2, {128{1'b1}}};
    tbl[4] = '{"single", 1,   'hBEEF,     1'b0, 16'h0,    16'h0,    16'h0,    1, 128'h3};

    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Input valid before any start: no acceptance
    no_ready_window("prestart", 6);

    for (int t = 0; t < 5; t++) run_case(tbl[t]);

    // ap_start held high: exactly one run
    vq.delete();
    vq.push_back(16'h0007);
    vq.push_back(16'h0008);
    build_exp();
    got_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #1 ap_start = 1'b1;
    send_range(0, 2, 1'b1);
    wait_done("held");
    compare_beats("held");
    no_ready_window("held", 8);
    chk("held_done_once", 1024'(done_cnt), 1024'(1));
    chk("held_idle", 1024'(ap_idle), 1024'(1));
    ap_start = 1'b0;

    // ap_start toggled while BUSY is ignored
    vq.delete();
    for (int i = 0; i < 64; i++) vq.push_back(16'(16'h0100 + i));
    build_exp();
    got_q.delete();
    done_cnt = 0;
    start_pulse();
    send_range(0, 10, 1'b0);
    start_pulse();
    send_range(10, 64, 1'b1);
    wait_done("toggle");
    compare_beats("toggle");
    chk("toggle_done_once", 1024'(done_cnt), 1024'(1));
    no_ready_window("toggle", 6);

    // Backpressure: hold the first full word for 10 cycles
    vq.delete();
    for (int i = 0; i < 130; i++) vq.push_back(16'(i));
    build_exp();
    got_q.delete();
    done_cnt = 0;
    m_ready = 1'b0;
    start_pulse();
    fork
      send_range(0, 130, 1'b1);
      begin
        logic [1023:0] snap;
        int g;
        g = 0;
        @(negedge clk);
        while (!m_valid && g < 500) begin
          @(negedge clk);
          g++;
        end
        chk("stall_valid_seen", 1024'(m_valid), 1024'(1));
        snap = m_data;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk($sformatf("stall_c%0d_data", i), m_data, snap);
          chk($sformatf("stall_c%0d_tready", i), 1024'(in_ready), 1024'(0));
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_done("stall");
    compare_beats("stall");

    // Reset mid-packet discards the partial word
    vq.delete();
    for (int i = 0; i < 10; i++) vq.push_back(16'(16'h0300 + i));
    start_pulse();
    send_range(0, 10, 1'b0);
    rst_n = 1'b0;
    #1 chk_reset("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    vq.delete();
    for (int i = 0; i < 64; i++) vq.push_back(16'(16'h5000 + i));
    build_exp();
    got_q.delete();
    done_cnt = 0;
    start_pulse();
    send_range(0, 64, 1'b1);
    wait_done("restart");
    compare_beats("restart");

    // Reset while a full word is held at the output
    vq.delete();
    for (int i = 0; i < 64; i++) vq.push_back(16'(16'h7000 + i));
    m_ready = 1'b0;
    start_pulse();
    send_range(0, 64, 1'b0);
    chk("held_word_valid", 1024'(m_valid), 1024'(1));
    rst_n = 1'b0;
    #1 chk_reset("held_out");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 1024'(ap_idle), 1024'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
